iopmp_reg_if: RTL and testbench

- Bus-side front end of the IOPMP control port.
- Accepts TL-UL-lite A-channel requests and decodes them into per-register write strobes and write data for the bank of register handlers.
- Returns handler q values, or write acks, on the D channel.
- Allows a single outstanding transaction; responds with an error on malformed or unmapped accesses.

---
 rtl/iopmp_reg_if.sv | 105 ++++++++++
 tb/tb_iopmp_reg_if.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/iopmp_reg_if.sv
// Bus-side front end of the IOPMP control port: decodes TL-UL-lite A-channel
// requests into register write strobes and returns handler q values on D.
module iopmp_reg_if #(
  parameter int unsigned AddrWidth   = 12,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned NumRegs     = 16,
  parameter int unsigned SourceWidth = 8,
  parameter logic [NumRegs-1:0] RoMask = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           a_valid,
  output logic                           a_ready,
  input  logic [2:0]                     a_opcode,
  input  logic [AddrWidth-1:0]           a_address,
  input  logic [DataWidth/8-1:0]         a_mask,
  input  logic [DataWidth-1:0]           a_data,
  input  logic [SourceWidth-1:0]         a_source,
  output logic                           d_valid,
  input  logic                           d_ready,
  output logic [2:0]                     d_opcode,
  output logic [DataWidth-1:0]           d_data,
  output logic                           d_error,
  output logic [SourceWidth-1:0]         d_source,
  output logic [NumRegs-1:0]             reg_we,
  output logic [DataWidth-1:0]           reg_data,
  input  logic [NumRegs*DataWidth-1:0]   reg_q
);

  localparam int unsigned IW = (NumRegs > 1) ? $clog2(NumRegs) : 1;

  localparam logic [2:0] OpPutFull    = 3'd0;
  localparam logic [2:0] OpPutPartial = 3'd1;
  localparam logic [2:0] OpGet        = 3'd4;
  localparam logic [2:0] OpAck        = 3'd0;
  localparam logic [2:0] OpAckData    = 3'd1;

  typedef enum logic {IDLE, RESP} state_t;

  state_t               state;
  logic [IW-1:0]        idx_c;
  logic                 is_get_c;
  logic                 is_put_c;
  logic                 err_c;
  logic [DataWidth-1:0] rdata_c;

  assign idx_c   = a_address[2 +: IW];
  assign a_ready = (state == IDLE);

  // Request decode: error classification and read-data mux
  always_comb begin
    is_get_c = (a_opcode == OpGet);
    is_put_c = (a_opcode == OpPutFull) || (a_opcode == OpPutPartial);
    err_c    = (a_address[1:0] != 2'b00)
            || ((a_address >> (2 + IW)) != '0)
            || (32'(idx_c) >= NumRegs)
            || !(is_get_c || is_put_c)
            || (is_put_c && (a_mask != '1));
    rdata_c  = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (idx_c == IW'(i)) rdata_c = reg_q[i*DataWidth +: DataWidth];
    end
  end

  // Single-outstanding FSM; response and strobe captured on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      d_valid  <= 1'b0;
      d_opcode <= '0;
      d_data   <= '0;
      d_error  <= 1'b0;
      d_source <= '0;
      reg_we   <= '0;
      reg_data <= '0;
    end else begin
      reg_we <= '0;
      case (state)
        IDLE: begin
          if (a_valid) begin
            state    <= RESP;
            d_valid  <= 1'b1;
            d_source <= a_source;
            d_error  <= err_c;
            d_opcode <= is_get_c ? OpAckData : OpAck;
            d_data   <= (is_get_c && !err_c) ? rdata_c : '0;
            // Read-only registers silently absorb the write but still ack cleanly
            if (is_put_c && !err_c && !RoMask[idx_c]) begin
              reg_we   <= NumRegs'(1) << idx_c;
              reg_data <= a_data;
            end
          end
        end
        RESP: begin
          if (d_ready) begin
            state   <= IDLE;
            d_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iopmp_reg_if.sv
// Self-checking bench for iopmp_reg_if: spec-level reference model plus
// register handler model, checked every cycle, with directed literal checks.
module tb_iopmp_reg_if;

  localparam int unsigned NR = 16;
  localparam logic [NR-1:0] RO_MASK = 16'h0001;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid;
  logic          a_ready;
  logic [2:0]    a_opcode;
  logic [11:0]   a_address;
  logic [3:0]    a_mask;
  logic [31:0]   a_data;
  logic [7:0]    a_source;
  logic          d_valid;
  logic          d_ready;
  logic [2:0]    d_opcode;
  logic [31:0]   d_data;
  logic          d_error;
  logic [7:0]    d_source;
  logic [NR-1:0] reg_we;
  logic [31:0]   reg_data;
  logic [NR*32-1:0] reg_q;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  iopmp_reg_if #(
    .AddrWidth(12), .DataWidth(32), .NumRegs(NR), .SourceWidth(8), .RoMask(RO_MASK)
  ) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .a_source(a_source),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_data(d_data),
    .d_error(d_error), .d_source(d_source),
    .reg_we(reg_we), .reg_data(reg_data), .reg_q(reg_q)
  );

  always #5 clk = ~clk;

  // Register handler model: each handler loads reg_data when its strobe is high
  logic [31:0] regs [NR];
  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (rst) regs[i] <= 32'hA5A5_0000 + 32'(i);
      else if (reg_we[i]) regs[i] <= reg_data;
    end
  end
  for (genvar g = 0; g < NR; g++) begin : g_q
    assign reg_q[g*32 +: 32] = regs[g];
  end

  // Reference model: one transaction in flight, response computed from the rules
  logic          m_busy;
  logic [2:0]    m_opc;
  logic [31:0]   m_data;
  logic          m_err;
  logic [7:0]    m_src;
  logic [NR-1:0] m_we;
  logic [31:0]   m_wdata;

  always @(posedge clk) begin : model
    int unsigned word;
    bit is_wr, is_rd, e;
    if (rst) begin
      m_busy <= 0; m_opc <= 0; m_data <= 0; m_err <= 0; m_src <= 0;
      m_we <= 0; m_wdata <= 0;
    end else begin
      m_we <= 0;
      if (!m_busy) begin
        if (a_valid) begin
          word  = 32'(a_address) / 4;
          is_rd = (a_opcode == 3'd4);
          is_wr = (a_opcode == 3'd0) || (a_opcode == 3'd1);
          e = (32'(a_address) % 4 != 0) || (word >= NR) || !(is_rd || is_wr)
              || (is_wr && a_mask != 4'hF);
          m_busy <= 1;
          m_src  <= a_source;
          m_err  <= e;
          m_opc  <= is_rd ? 3'd1 : 3'd0;
          m_data <= (is_rd && !e) ? regs[word] : 32'd0;
          if (is_wr && !e && !RO_MASK[word]) begin
            m_we    <= NR'(1) << word;
            m_wdata <= a_data;
          end
        end
      end else if (d_ready) begin
        m_busy <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_ready",  64'(a_ready),  64'(!m_busy));
      chk("d_valid",  64'(d_valid),  64'(m_busy));
      chk("d_opcode", 64'(d_opcode), 64'(m_opc));
      chk("d_data",   64'(d_data),   64'(m_data));
      chk("d_error",  64'(d_error),  64'(m_err));
      chk("d_source", 64'(d_source), 64'(m_src));
      chk("reg_we",   64'(reg_we),   64'(m_we));
      chk("reg_data", 64'(reg_data), 64'(m_wdata));
    end
  end

  // Present one request at a negedge; returns at the negedge after it is accepted
  task automatic do_req(input logic [2:0] op, input logic [11:0] addr,
                        input logic [3:0] mask, input logic [31:0] data,
                        input logic [7:0] src);
    bit acc = 0;
    a_valid = 1; a_opcode = op; a_address = addr; a_mask = mask;
    a_data = data; a_source = src;
    for (int k = 0; k < 20; k++) begin
      if (a_ready) begin
        @(negedge clk);
        acc = 1;
        break;
      end
      @(negedge clk);
    end
    a_valid = 0;
    chk("accept_timeout", 64'(acc), 64'd1);
  endtask

  typedef struct {logic [2:0] op; logic [11:0] addr; logic [3:0] mask;} err_vec_t;
  err_vec_t ev [4];

  initial begin
    ev[0] = '{3'd4, 12'h002, 4'hF};
    ev[1] = '{3'd4, 12'h040, 4'hF};
    ev[2] = '{3'd1, 12'h010, 4'h3};
    ev[3] = '{3'd2, 12'h010, 4'hF};

    rst = 1; a_valid = 0; a_opcode = 0; a_address = 0; a_mask = 0;
    a_data = 0; a_source = 0; d_ready = 1;
    @(negedge clk);
    chk_en = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_a_ready", 64'(a_ready), 64'd1);
    chk("rst_d_valid", 64'(d_valid), 64'd0);
    chk("rst_reg_we",  64'(reg_we),  64'd0);
    chk("rst_d_data",  64'(d_data),  64'd0);

    // Write reg 3, then read it back immediately
    do_req(3'd0, 12'h00C, 4'hF, 32'hDEADBEEF, 8'h5A);
    chk("wr3_we",     64'(reg_we),   64'h0008);
    chk("wr3_data",   64'(reg_data), 64'hDEADBEEF);
    chk("wr3_valid",  64'(d_valid),  64'd1);
    chk("wr3_opcode", 64'(d_opcode), 64'd0);
    chk("wr3_error",  64'(d_error),  64'd0);
    chk("wr3_source", 64'(d_source), 64'h5A);
    @(negedge clk);
    chk("wr3_we_gone", 64'(reg_we), 64'd0);
    do_req(3'd4, 12'h00C, 4'hF, 32'd0, 8'h11);
    chk("rd3_opcode", 64'(d_opcode), 64'd1);
    chk("rd3_data",   64'(d_data),   64'hDEADBEEF);
    chk("rd3_source", 64'(d_source), 64'h11);

    // Malformed and unmapped accesses
    foreach (ev[i]) begin
      @(negedge clk);
      do_req(ev[i].op, ev[i].addr, ev[i].mask, 32'hFFFF_FFFF, 8'(i));
      chk("err_flag",  64'(d_error), 64'd1);
      chk("err_data",  64'(d_data),  64'd0);
      chk("err_no_we", 64'(reg_we),  64'd0);
    end

    // Read-only register 0 acks cleanly but is not written
    @(negedge clk);
    do_req(3'd0, 12'h000, 4'hF, 32'h1234_5678, 8'h22);
    chk("ro_error", 64'(d_error), 64'd0);
    chk("ro_no_we", 64'(reg_we),  64'd0);
    @(negedge clk);
    do_req(3'd4, 12'h000, 4'hF, 32'd0, 8'h23);
    chk("ro_read", 64'(d_data), 64'hA5A5_0000);

    // Top register boundary
    @(negedge clk);
    do_req(3'd1, 12'h03C, 4'hF, 32'hCAFE_F00D, 8'h33);
    chk("wr15_we", 64'(reg_we), 64'h8000);
    @(negedge clk);
    do_req(3'd4, 12'h03C, 4'hF, 32'd0, 8'h34);
    chk("rd15_data", 64'(d_data), 64'hCAFE_F00D);

    // Stall with d_ready low, then reset while the response is pending
    @(negedge clk);
    d_ready = 0;
    do_req(3'd4, 12'h00C, 4'hF, 32'd0, 8'h77);
    for (int c = 0; c < 10; c++) begin
      chk("stall_valid",  64'(d_valid),  64'd1);
      chk("stall_data",   64'(d_data),   64'hDEADBEEF);
      chk("stall_source", 64'(d_source), 64'h77);
      chk("stall_ready",  64'(a_ready),  64'd0);
      @(negedge clk);
    end
    rst = 1;
    @(negedge clk);
    chk("rst_resp_valid", 64'(d_valid), 64'd0);
    chk("rst_resp_ready", 64'(a_ready), 64'd1);
    chk("rst_resp_we",    64'(reg_we),  64'd0);
    rst = 0;
    d_ready = 1;
    @(negedge clk);
    do_req(3'd0, 12'h014, 4'hF, 32'h0BAD_CAFE, 8'h44);
    chk("post_rst_we", 64'(reg_we), 64'h0020);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
